// File: rtl/isa_cycle_pkg.sv
// Shared types for the ISA cycle initiator: FSM states, command codes, strobe bundle.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package isa_cycle_pkg;

  // Cycle phases of the initiator FSM.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Command encoding is {io, write}, exactly as presented on the request port.
  typedef enum logic [1:0] {
    CMD_MEMR = 2'b00,
    CMD_MEMW = 2'b01,
    CMD_IOR  = 2'b10,
    CMD_IOW  = 2'b11
  } cmd_t;

  // The four active-low bus strobes, kept together so they are updated as one register.
  typedef struct packed {
    logic ior_l;
    logic iow_l;
    logic memr_l;
    logic memw_l;
  } strobe_t;

  // Value seen on an undriven data bus; also returned for writes and aborted cycles.
  localparam logic [7:0] FLOAT_BYTE = 8'hFF;

  localparam strobe_t STROBES_IDLE = strobe_t'(4'b1111);

  // Exactly one strobe is pulled low for a given command.
  function automatic strobe_t strobe_for(input cmd_t cmd);
    strobe_t s;
    s = STROBES_IDLE;
    case (cmd)
      CMD_MEMR: s.memr_l = 1'b0;
      CMD_MEMW: s.memw_l = 1'b0;
      CMD_IOR:  s.ior_l  = 1'b0;
      CMD_IOW:  s.iow_l  = 1'b0;
      default:  s = STROBES_IDLE;
    endcase
    return s;
  endfunction

  function automatic logic is_write(input cmd_t cmd);
    return (cmd == CMD_MEMW) || (cmd == CMD_IOW);
  endfunction

endpackage

// File: rtl/isa_phase_timer.sv
// Phase timer: 8-bit loadable down-counter with a zero flag, shared by every cycle phase.
// Latency: load/decrement take effect at the next clock; o_zero follows the register directly.
// Backpressure: none; load wins over decrement and the count saturates at zero.
module isa_phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [7:0] r_count;

  // Count register: reload on phase entry, otherwise step down towards zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 8'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_zero = (r_count == 8'd0);

endmodule

// File: rtl/isa_cycle_master.sv
// ISA cycle initiator: one host request becomes one timed I/O or memory cycle on the shared bus.
// Latency: SETUP+STROBE+ext+HOLD clocks from accept edge to the registered one-clock rsp_valid.
// Backpressure: req_ready only in IDLE, requests offered while busy are dropped; bus_rdy low stretches the strobe.
module isa_cycle_master
  import isa_cycle_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1,
  parameter int RDY_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_io,
  input  logic [14:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [14:0] bus_a,
  output logic [7:0]  bus_d,
  output logic        bus_ior_l,
  output logic        bus_iow_l,
  output logic        bus_memr_l,
  output logic        bus_memw_l,
  output logic        bus_aen,
  input  logic [7:0]  bus_out,
  input  logic        bus_dir,
  input  logic        bus_rdy
);

  // The timer counts down from N-1 so that a phase ends on the clock its count is zero.
  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HOLD_LD   = (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES - 1) : 8'd0;
  localparam logic [7:0] RDY_LD    = (RDY_TIMEOUT > 0) ? 8'(RDY_TIMEOUT - 1) : 8'd0;
  localparam logic       NO_HOLD   = (HOLD_CYCLES == 0);
  localparam logic       RDY_ZERO  = (RDY_TIMEOUT == 0);

  state_t      r_state,   w_state_nxt;
  strobe_t     r_strb,    w_strb_nxt;
  cmd_t        r_cmd,     w_cmd_nxt;
  logic        r_aen,     w_aen_nxt;
  logic [14:0] r_a,       w_a_nxt;
  logic [7:0]  r_d,       w_d_nxt;
  logic        r_ext,     w_ext_nxt;
  logic [7:0]  r_cap_dat, w_cap_dat_nxt;
  logic        r_cap_err, w_cap_err_nxt;
  logic        r_rsp_vld, w_rsp_vld_nxt;
  logic [7:0]  r_rsp_dat, w_rsp_dat_nxt;
  logic        r_rsp_err, w_rsp_err_nxt;
  logic        r_ready;

  logic        w_tmr_load;
  logic [7:0]  w_tmr_val;
  logic        w_tmr_dec;
  logic        w_tmr_zero;
  logic        w_exit;
  logic        w_timeout;
  logic [7:0]  w_sample;

  isa_phase_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  // Next-state and next-output logic; every register's next value defaults to hold.
  always_comb begin
    w_state_nxt   = r_state;
    w_strb_nxt    = r_strb;
    w_cmd_nxt     = r_cmd;
    w_aen_nxt     = r_aen;
    w_a_nxt       = r_a;
    w_d_nxt       = r_d;
    w_ext_nxt     = r_ext;
    w_cap_dat_nxt = r_cap_dat;
    w_cap_err_nxt = r_cap_err;
    w_rsp_vld_nxt = 1'b0;
    w_rsp_dat_nxt = r_rsp_dat;
    w_rsp_err_nxt = r_rsp_err;
    w_tmr_load    = 1'b0;
    w_tmr_val     = 8'd0;
    w_tmr_dec     = 1'b0;
    w_exit        = 1'b0;
    w_timeout     = 1'b0;
    // Writes and an undriven bus both read back as the floating value.
    w_sample      = (is_write(r_cmd) || !bus_dir) ? FLOAT_BYTE : bus_out;

    case (r_state)
      IDLE: begin
        if (req_valid && r_ready) begin
          w_cmd_nxt   = cmd_t'({req_io, req_write});
          w_a_nxt     = req_addr;
          w_d_nxt     = req_wdata;
          w_aen_nxt   = 1'b0;
          w_state_nxt = ADDR;
          w_tmr_load  = 1'b1;
          w_tmr_val   = SETUP_LD;
        end
      end

      ADDR: begin
        if (w_tmr_zero) begin
          w_state_nxt = STROBE;
          w_strb_nxt  = strobe_for(r_cmd);
          w_ext_nxt   = 1'b0;
          w_tmr_load  = 1'b1;
          w_tmr_val   = STROBE_LD;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end

      STROBE: begin
        // bus_rdy is only looked at from the last minimum clock onwards.
        if (!r_ext && !w_tmr_zero) begin
          w_tmr_dec = 1'b1;
        end else if (bus_rdy) begin
          w_exit = 1'b1;
        end else if (r_ext ? w_tmr_zero : RDY_ZERO) begin
          w_exit    = 1'b1;
          w_timeout = 1'b1;
        end else if (!r_ext) begin
          // First wait clock: switch the shared timer over to counting extension clocks.
          w_ext_nxt  = 1'b1;
          w_tmr_load = 1'b1;
          w_tmr_val  = RDY_LD;
        end else begin
          w_tmr_dec = 1'b1;
        end

        if (w_exit) begin
          w_strb_nxt    = STROBES_IDLE;
          w_ext_nxt     = 1'b0;
          w_cap_dat_nxt = w_timeout ? FLOAT_BYTE : w_sample;
          w_cap_err_nxt = w_timeout;
          if (NO_HOLD) begin
            w_state_nxt   = IDLE;
            w_aen_nxt     = 1'b1;
            w_rsp_vld_nxt = 1'b1;
            w_rsp_dat_nxt = w_cap_dat_nxt;
            w_rsp_err_nxt = w_cap_err_nxt;
          end else begin
            w_state_nxt = HOLD;
            w_tmr_load  = 1'b1;
            w_tmr_val   = HOLD_LD;
          end
        end
      end

      HOLD: begin
        if (w_tmr_zero) begin
          w_state_nxt   = IDLE;
          w_aen_nxt     = 1'b1;
          w_rsp_vld_nxt = 1'b1;
          w_rsp_dat_nxt = r_cap_dat;
          w_rsp_err_nxt = r_cap_err;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_strb_nxt  = STROBES_IDLE;
        w_aen_nxt   = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any cycle in flight without a response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_strb    <= STROBES_IDLE;
      r_cmd     <= CMD_MEMR;
      r_aen     <= 1'b1;
      r_a       <= 15'd0;
      r_d       <= 8'd0;
      r_ext     <= 1'b0;
      r_cap_dat <= FLOAT_BYTE;
      r_cap_err <= 1'b0;
      r_rsp_vld <= 1'b0;
      r_rsp_dat <= FLOAT_BYTE;
      r_rsp_err <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_strb    <= w_strb_nxt;
      r_cmd     <= w_cmd_nxt;
      r_aen     <= w_aen_nxt;
      r_a       <= w_a_nxt;
      r_d       <= w_d_nxt;
      r_ext     <= w_ext_nxt;
      r_cap_dat <= w_cap_dat_nxt;
      r_cap_err <= w_cap_err_nxt;
      r_rsp_vld <= w_rsp_vld_nxt;
      r_rsp_dat <= w_rsp_dat_nxt;
      r_rsp_err <= w_rsp_err_nxt;
      r_ready   <= (w_state_nxt == IDLE);
    end
  end

  assign req_ready  = r_ready;
  assign rsp_valid  = r_rsp_vld;
  assign rsp_rdata  = r_rsp_dat;
  assign rsp_err    = r_rsp_err;
  assign bus_a      = r_a;
  assign bus_d      = r_d;
  assign bus_aen    = r_aen;
  assign bus_ior_l  = r_strb.ior_l;
  assign bus_iow_l  = r_strb.iow_l;
  assign bus_memr_l = r_strb.memr_l;
  assign bus_memw_l = r_strb.memw_l;

endmodule

// File: tb/tb_isa_cycle_master.sv
// Bench for isa_cycle_master: directed and random cycles against a timing/data reference model.
// Latency: expected per-transaction response latency comes from the model.
// Backpressure: driver waits on req_ready; junk requests are offered while the block is busy.
module tb_isa_cycle_master;

  localparam int SETUP = 1;
  localparam int STB   = 4;
  localparam int HOLD  = 1;
  localparam int TMO   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_io = 1'b0;
  logic [14:0] req_addr = 15'd0;
  logic [7:0]  req_wdata = 8'd0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [14:0] bus_a;
  logic [7:0]  bus_d;
  logic        bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l;
  logic        bus_aen;
  logic [7:0]  bus_out = 8'd0;
  logic        bus_dir = 1'b0;
  logic        bus_rdy = 1'b1;

  isa_cycle_master #(
    .SETUP_CYCLES  (SETUP),
    .STROBE_CYCLES (STB),
    .HOLD_CYCLES   (HOLD),
    .RDY_TIMEOUT   (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_io     (req_io),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .bus_a      (bus_a),
    .bus_d      (bus_d),
    .bus_ior_l  (bus_ior_l),
    .bus_iow_l  (bus_iow_l),
    .bus_memr_l (bus_memr_l),
    .bus_memw_l (bus_memw_l),
    .bus_aen    (bus_aen),
    .bus_out    (bus_out),
    .bus_dir    (bus_dir),
    .bus_rdy    (bus_rdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          acc;
    bit          wr;
    bit          io;
    logic [14:0] addr;
    logic [7:0]  wd;
    int          width;
    int          lat;
    logic [7:0]  rd;
    bit          err;
  } exp_t;

  exp_t q[$];
  int   cfg_nlow = 0;
  bit   abort_ok = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model: timing and data follow directly from the cycle rules.
  function automatic exp_t model(input bit wr, input bit io, input logic [14:0] a,
                                 input logic [7:0] wd, input bit dir, input logic [7:0] bo,
                                 input int nlow);
    exp_t e;
    int   ext;
    ext     = (nlow > TMO) ? TMO : nlow;
    e.acc   = 0;
    e.wr    = wr;
    e.io    = io;
    e.addr  = a;
    e.wd    = wd;
    e.width = STB + ext;
    e.lat   = SETUP + STB + ext + HOLD;
    e.err   = (nlow > TMO);
    e.rd    = (e.err || wr || !dir) ? 8'hFF : bo;
    return e;
  endfunction

  // Expected {ior,iow,memr,memw} while the strobe is active.
  function automatic logic [3:0] exp_strb(input bit io, input bit wr);
    if (io && wr)  return 4'b1011;
    if (io)        return 4'b0111;
    if (wr)        return 4'b1110;
    return 4'b1101;
  endfunction

  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_ready_wait: got 0 expected 1 within 100 cycles at cycle %0d", cyc);
    end
  endtask

  task automatic issue(input bit wr, input bit io, input logic [14:0] a, input logic [7:0] wd,
                       input bit dir, input logic [7:0] bo, input int nlow, input bit push);
    exp_t e;
    int   junk;
    wait_ready();
    req_valid = 1'b1;
    req_write = wr;
    req_io    = io;
    req_addr  = a;
    req_wdata = wd;
    bus_dir   = dir;
    bus_out   = bo;
    cfg_nlow  = nlow;
    e = model(wr, io, a, wd, dir, bo, nlow);
    @(posedge clk);
    #1;
    e.acc = cyc;
    if (push) q.push_back(e);
    // Requests offered while busy must be ignored.
    junk = $urandom_range(0, 3);
    for (int i = 0; i < junk; i++) begin
      req_valid = 1'b1;
      req_write = 1'($urandom_range(0, 1));
      req_io    = 1'($urandom_range(0, 1));
      req_addr  = 15'($urandom);
      req_wdata = 8'($urandom);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic reset_mid();
    int t;
    t = 0;
    abort_ok = 1'b1;
    issue(1'b0, 1'b1, 15'h3DA, 8'h00, 1'b1, 8'h55, 0, 1'b0);
    while (bus_ior_l && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("rst_reached_strobe", bus_ior_l, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_strobes", {bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l}, 4'hF);
    chk("rst_aen", bus_aen, 1'b1);
    chk("rst_ready", req_ready, 1'b1);
    reset    = 1'b0;
    abort_ok = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  // Responder: bus_rdy is random outside the wait window, low for cfg_nlow clocks from the last minimum clock.
  initial begin : responder
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if (bus_ior_l && bus_iow_l && bus_memr_l && bus_memw_l) k = 0;
      else k++;
      if (k < STB) bus_rdy = 1'($urandom_range(0, 1));
      else         bus_rdy = (k >= STB + cfg_nlow);
    end
  end

  // Monitor: compares bus activity and responses against the head of the scoreboard.
  initial begin : monitor
    int         lowcnt;
    int         lows;
    logic       prev_aen;
    logic [3:0] strb;
    exp_t       e;
    lowcnt   = 0;
    prev_aen = 1'b1;
    forever begin
      @(negedge clk);
      strb = {bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l};
      lows = 0;
      for (int i = 0; i < 4; i++) if (!strb[i]) lows++;
      if (reset) begin
        lowcnt   = 0;
        prev_aen = 1'b1;
      end else begin
        chk("at_most_one_strobe", (lows <= 1), 1'b1);
        if (q.size() == 0) begin
          lowcnt = 0;
          if (lows != 0 && !abort_ok) chk("idle_strobe", strb, 4'hF);
          if (rsp_valid) chk("unexpected_rsp", rsp_valid, 1'b0);
        end else begin
          e = q[0];
          if (prev_aen && !bus_aen) chk("aen_fall_cycle", cyc - e.acc, 0);
          if (!bus_aen) begin
            chk("bus_a_stable", bus_a, e.addr);
            chk("bus_d_stable", bus_d, e.wd);
          end
          if (lows != 0) begin
            if (lowcnt == 0) chk("strobe_fall_cycle", cyc - e.acc, SETUP);
            chk("strobe_select", strb, exp_strb(e.io, e.wr));
            chk("aen_during_strobe", bus_aen, 1'b0);
            lowcnt++;
          end else if (lowcnt != 0) begin
            chk("strobe_width", lowcnt, e.width);
            lowcnt = 0;
          end
          if (rsp_valid) begin
            void'(q.pop_front());
            chk("rsp_latency", cyc - e.acc, e.lat);
            chk("rsp_rdata", rsp_rdata, e.rd);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_aen_released", bus_aen, 1'b1);
            chk("rsp_bus_a_kept", bus_a, e.addr);
          end
        end
        prev_aen = bus_aen;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int r;
    int nlow;
    int t;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", req_ready, 1'b1);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_err", rsp_err, 1'b0);
    chk("reset_rsp_rdata", rsp_rdata, 8'hFF);
    chk("reset_strobes", {bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l}, 4'hF);
    chk("reset_aen", bus_aen, 1'b1);
    chk("reset_bus_a", bus_a, 15'd0);
    chk("reset_bus_d", bus_d, 8'd0);
    reset = 1'b0;

    issue(1'b1, 1'b1, 15'h3D8, 8'h29, 1'b0, 8'h00, 0, 1'b1);
    issue(1'b0, 1'b1, 15'h3DA, 8'h00, 1'b1, 8'hF9, 0, 1'b1);
    issue(1'b0, 1'b1, 15'h3DA, 8'h00, 1'b0, 8'hF9, 0, 1'b1);
    issue(1'b0, 1'b0, 15'h0B80, 8'h00, 1'b1, 8'h3C, 3, 1'b1);
    issue(1'b0, 1'b0, 15'h0B81, 8'h00, 1'b1, 8'h3C, 20, 1'b1);
    issue(1'b1, 1'b0, 15'h7FFF, 8'hFF, 1'b1, 8'h12, 0, 1'b1);

    reset_mid();
    issue(1'b1, 1'b0, 15'h1234, 8'hA5, 1'b0, 8'h00, 0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      r    = $urandom_range(0, 6);
      nlow = (r < 4) ? r : r + 1;
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 15'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), 8'($urandom), nlow, 1'b1);
    end

    t = 0;
    while (q.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
